// File: rtl/result_drain.sv
// result_drain: pops the bit-serial result FIFO, regroups bits MSB-first into
// 5-bit digits and streams them as base32hex ASCII, one newline per record.
// A FIFO overflow seen during a record appends '!' before that record's newline.
module result_drain #(
   parameter int RECORD_BITS = 100,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic             fifo_oflow,
   output logic             fifo_req,
   input  logic             fifo_bit,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] rec_count
);

   localparam int CHARS = RECORD_BITS / 5;
   localparam int CHR_W = (CHARS > 1) ? $clog2(CHARS) : 1;
   localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(CHARS - 1);

   typedef enum logic [2:0] {
      ST_REQ,
      ST_CAP,
      ST_EMIT,
      ST_BANG,
      ST_NL
   } state_t;

   state_t             state_reg, state_next;
   logic [4:0]         dig_reg, dig_next;
   logic [2:0]         bit_cnt_reg, bit_cnt_next;
   logic [CHR_W-1:0]   chr_cnt_reg, chr_cnt_next;
   logic               ovf_reg, ovf_next;
   logic               run_reg;
   logic [7:0]         out_data_reg;
   logic               out_valid_reg;
   logic               nl_pend_reg;
   logic [CNT_W-1:0]   rec_count_reg;

   logic               out_free;
   logic               load;
   logic               load_nl;
   logic [7:0]         load_char;
   logic [7:0]         char_lut [32];

   // Digit to base32hex character table: '0'..'9' then 'a'..'v'.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_lut
         assign char_lut[gi] = (gi < 10) ? 8'(48 + gi) : 8'(87 + gi);
      end
   endgenerate

   // The single output slot can take a new character when empty or draining now.
   assign out_free = !out_valid_reg || out_ready;

   // Next-state and datapath control; all loads go through the one output slot.
   always_comb begin
      state_next   = state_reg;
      dig_next     = dig_reg;
      bit_cnt_next = bit_cnt_reg;
      chr_cnt_next = chr_cnt_reg;
      ovf_next     = ovf_reg | fifo_oflow;
      fifo_req     = 1'b0;
      load         = 1'b0;
      load_nl      = 1'b0;
      load_char    = 8'h00;
      case (state_reg)
         ST_REQ: begin
            // run_reg keeps the pop request quiet while reset is held.
            if (run_reg && !fifo_empty) begin
               fifo_req   = 1'b1;
               state_next = ST_CAP;
            end
         end
         ST_CAP: begin
            dig_next = {dig_reg[3:0], fifo_bit};
            if (bit_cnt_reg == 3'd4) begin
               bit_cnt_next = 3'd0;
               state_next   = ST_EMIT;
            end else begin
               bit_cnt_next = bit_cnt_reg + 3'd1;
               state_next   = ST_REQ;
            end
         end
         ST_EMIT: begin
            if (out_free) begin
               load      = 1'b1;
               load_char = char_lut[dig_reg];
               if (chr_cnt_reg == CHR_LAST) begin
                  state_next = ovf_reg ? ST_BANG : ST_NL;
               end else begin
                  chr_cnt_next = chr_cnt_reg + CHR_W'(1);
                  state_next   = ST_REQ;
               end
            end
         end
         ST_BANG: begin
            if (out_free) begin
               load       = 1'b1;
               load_char  = 8'h21;
               // An overflow arriving right now belongs to the next record.
               ovf_next   = fifo_oflow;
               state_next = ST_NL;
            end
         end
         ST_NL: begin
            if (out_free) begin
               load         = 1'b1;
               load_nl      = 1'b1;
               load_char    = 8'h0A;
               chr_cnt_next = '0;
               state_next   = ST_REQ;
            end
         end
         default: state_next = ST_REQ;
      endcase
   end

   // FSM, counters, digit shifter and overflow latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_REQ;
         dig_reg     <= 5'd0;
         bit_cnt_reg <= 3'd0;
         chr_cnt_reg <= '0;
         ovf_reg     <= 1'b0;
         run_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         dig_reg     <= dig_next;
         bit_cnt_reg <= bit_cnt_next;
         chr_cnt_reg <= chr_cnt_next;
         ovf_reg     <= ovf_next;
         run_reg     <= 1'b1;
      end
   end

   // Output slot: a load wins over an accept so back-to-back bytes have no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= 8'h00;
         out_valid_reg <= 1'b0;
         nl_pend_reg   <= 1'b0;
      end else if (load) begin
         out_data_reg  <= load_char;
         out_valid_reg <= 1'b1;
         nl_pend_reg   <= load_nl;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // A record counts as complete only once its newline leaves the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_count_reg <= '0;
      end else if (out_valid_reg && out_ready && nl_pend_reg) begin
         rec_count_reg <= rec_count_reg + CNT_W'(1);
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign rec_count = rec_count_reg;

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: FIFO model feeding result_drain, scoreboard of expected bytes
// popped and compared by a monitor whenever a byte is accepted.
module tb_result_drain;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_oflow = 1'b0;
   logic        fifo_req;
   logic        fifo_bit = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] rec_count;

   always #5 clk = ~clk;

   result_drain #(.RECORD_BITS(100), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_oflow (fifo_oflow),
      .fifo_req   (fifo_req),
      .fifo_bit   (fifo_bit),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .rec_count  (rec_count)
   );

   int         compared = 0;
   int         mismatched = 0;
   logic [7:0] exp_q [$];
   bit         fq [$];
   int         pops = 0;
   int         gap_cnt = 0;
   int         oflow_at = 0;
   int         ready_mode = 0;
   bit         gap_mode = 1'b0;
   bit         req_seen = 1'b0;
   bit         prev_req = 1'b0;
   bit         stall_prev = 1'b0;
   logic [7:0] held = 8'h00;
   int         pops_at_accept = 0;
   int         nbytes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] char2dig(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return 5'(c - 8'h30);
      return 5'(c - 8'h57);
   endfunction

   // Queue the first nbits of a record, MSB-first per character.
   task automatic push_bits(input string s, input int nbits);
      logic [4:0] d;
      for (int b = 0; b < nbits; b++) begin
         d = char2dig(s[b / 5]);
         fq.push_back(d[4 - (b % 5)]);
      end
   endtask

   task automatic push_exp(input string s, input int nchars, input string suffix);
      for (int i = 0; i < nchars; i++) exp_q.push_back(s[i]);
      for (int j = 0; j < suffix.len(); j++) exp_q.push_back(suffix[j]);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fq.size() != 0 || out_valid) && n < limit) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= limit) begin
         mismatched++;
         $display("FAIL drain_timeout: %0d bytes still expected, %0d bits unread", exp_q.size(), fq.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // FIFO read side and downstream ready pattern, updated just after each edge.
   always @(posedge clk) begin
      #1;
      fifo_oflow = 1'b0;
      if (req_seen) begin
         req_seen = 1'b0;
         if (fq.size() > 0) fifo_bit = fq.pop_front();
         else fifo_bit = 1'b0;
         pops++;
         if (oflow_at != 0 && pops == oflow_at) fifo_oflow = 1'b1;
         gap_cnt = gap_mode ? int'($urandom_range(0, 10)) : 0;
      end else if (gap_cnt > 0) begin
         gap_cnt--;
      end
      fifo_empty = (fq.size() == 0) || (gap_cnt > 0);
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = !out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: request protocol, output hold rule and scoreboard compare.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         prev_req   = 1'b0;
      end else begin
         if (fifo_req) begin
            compared++;
            if (fifo_empty || prev_req) begin
               mismatched++;
               $display("FAIL req_protocol: empty=%0b prev_req=%0b required 0/0", fifo_empty, prev_req);
            end
         end
         req_seen = fifo_req;
         prev_req = fifo_req;
         if (stall_prev) begin
            compared++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               mismatched++;
               $display("FAIL hold_stable: valid=%0b data=0x%02h required 1/0x%02h", out_valid, out_data, held);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_byte: got 0x%02h with nothing expected", out_data);
            end else begin
               $display("byte %0d: got 0x%02h expected 0x%02h", nbytes, out_data, exp_q[0]);
               check("byte", 32'(out_data), 32'(exp_q.pop_front()));
            end
            nbytes++;
            pops_at_accept = pops;
         end
         stall_prev = out_valid && !out_ready;
         held       = out_data;
      end
   end

   initial begin
      string ra, rb, rc;
      bit got;
      int p0;
      ra = "5um2o2dhfj2q5lvdchhq";
      rb = "09av09av09av09av09av";
      rc = "v0a9lq3k8mbc7hj1u2o4";

      // Reset held with data waiting in the FIFO.
      push_bits(ra, 100);
      push_exp(ra, 20, "\n");
      repeat (5) @(negedge clk);
      check("reset_fifo_req", 32'(fifo_req), 0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_data", 32'(out_data), 0);
      check("reset_rec_count", 32'(rec_count), 0);
      rst_n = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (fifo_req) got = 1'b1;
      end
      check("first_req_latency", 32'(got), 1);
      wait_drain(2000);
      check("rec_count_single", 32'(rec_count), 1);

      // Backpressure: toggling ready, then a long stall mid-record.
      push_bits(ra, 100);
      push_exp(ra, 20, "\n");
      ready_mode = 1;
      repeat (60) @(negedge clk);
      ready_mode = 2;
      repeat (25) @(negedge clk);
      p0 = pops;
      repeat (15) @(negedge clk);
      check("stall_no_pops", 32'(pops - p0), 0);
      compared++;
      if (pops - pops_at_accept > 10) begin
         mismatched++;
         $display("FAIL stall_pop_bound: %0d pops since last accept, required <= 10", pops - pops_at_accept);
      end
      ready_mode = 0;
      wait_drain(2000);
      check("rec_count_backpressure", 32'(rec_count), 2);

      // Random empty gaps between bits.
      gap_mode = 1'b1;
      push_bits(ra, 100);
      push_exp(ra, 20, "\n");
      wait_drain(5000);
      gap_mode = 1'b0;
      check("rec_count_gaps", 32'(rec_count), 3);

      // Overflow pulse at bit 37 of the first of two records.
      pops = 0;
      oflow_at = 37;
      push_bits(ra, 100);
      push_bits(rb, 100);
      push_exp(ra, 20, "!\n");
      push_exp(rb, 20, "\n");
      wait_drain(3000);
      oflow_at = 0;
      check("rec_count_overflow", 32'(rec_count), 5);

      // Reset after 53 bits, then a fresh record.
      pops = 0;
      push_bits(rc, 53);
      push_exp(rc, 10, "");
      wait_drain(1000);
      check("pops_before_reset", 32'(pops), 53);
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 32'(out_valid), 0);
      check("midreset_rec_count", 32'(rec_count), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_bits(rc, 100);
      push_exp(rc, 20, "\n");
      wait_drain(2000);
      check("rec_count_after_reset", 32'(rec_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/result_drain.md
# result_drain

Downstream consumer of the hash block's bit-serial result FIFO. Pops result bits one at a time through the `fifo_req`/`fifo_bit` read port and regroups them MSB-first into 5-bit digits. Each digit is emitted as a lowercase base32hex ASCII character on a byte stream with valid/ready handshake, and each record ends with a newline, so results can go straight to a UART or host link. Records are RECORD_BITS long; the default 100 bits produces 20 characters, e.g. `5um2o2dhfj2q5lvdchhq\n`.

## Interface
- RECORD_BITS, 100, bits per result record; must be a nonzero multiple of 5.
- CNT_W, 16, width of the completed-record counter.

- clk  in  1  system clock; same clock as the FIFO read side (`fifo_clk`).
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO has no bits; sampled every cycle.
- fifo_oflow  in  1  FIFO overflow flag; any high sample is latched.
- fifo_req  out  1  one-cycle pop request.
- fifo_bit  in  1  popped bit; valid the cycle after `fifo_req`.
- out_data  out  8  ASCII character.
- out_valid  out  1  `out_data` is valid; held until accepted.
- out_ready  in  1  downstream accepts when `out_valid && out_ready`.
- rec_count  out  CNT_W  completed records (newline accepted); wraps.

## Operation
- Digit shift register `dig[4:0]` takes bits MSB-first: `dig <= {dig[3:0], fifo_bit}`.
- Counters:
  - `bit_cnt` runs 0..4.
  - `chr_cnt` runs 0..RECORD_BITS/5-1.
- Oflow latch `ovf` sets on any cycle with `fifo_oflow=1`.
- States:
  - IDLE/REQ: if `!fifo_empty`, assert `fifo_req` for one cycle, go to CAP.
  - CAP: shift `fifo_bit` in, increment `bit_cnt`.
    - If `bit_cnt` was 4: go to EMIT.
    - Otherwise: go to REQ.
  - EMIT: load the output register if it is empty or being accepted this cycle; otherwise stall here without requesting.
    - After loading, if `chr_cnt` was last: go to BANG if `ovf`, else go to NL.
    - Otherwise: increment `chr_cnt` and go to REQ.
  - BANG: load `'!'` (0x21) into the output register, same load rule as EMIT; clear `ovf`; go to NL.
  - NL: load 0x0A, same load rule; clear `chr_cnt`; go to REQ.
- Character mapping:
  - digit 0–9 → 0x30+d.
  - digit 10–31 → 0x61+d−10 ('a'..'v').
- Output register: one entry.
  - Load sets `out_valid`.
  - Acceptance without a simultaneous load clears `out_valid`.
  - Simultaneous accept and load: new character replaces the old one with no bubble.
- `rec_count` increments when the newline is accepted downstream, not when it is loaded.
- `ovf` behaviour:
  - Reported once per record: affects the record in progress, or the next record if set while in NL.
  - A `fifo_oflow` high in the same cycle as the clear in BANG re-sets `ovf`.
- Record boundaries come only from counting bits. The drain never resynchronises on FIFO content.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `fifo_req`=0, `out_valid`=0, `out_data`=0x00, `rec_count`=0.
  - State REQ; `bit_cnt`=`chr_cnt`=0; `ovf`=0; `dig`=0.
- At most one request is outstanding. `fifo_req` is never high in two consecutive cycles. Peak rate is one bit per 2 cycles.
- `fifo_req` is asserted only in a cycle where `fifo_empty`=0 is sampled.
- `fifo_bit` is captured exactly 1 cycle after `fifo_req`, regardless of `fifo_empty` in the capture cycle.
- Latency from the 5th request to `out_valid`:
  - Capture at +1.
  - EMIT at +2, loads the output register.
  - `out_valid` high at +3.
- `out_valid` never drops, and `out_data` never changes, while `out_valid && !out_ready`.
- With `out_ready` held low, the block pops at most 5 further bits (one digit) and then stalls in EMIT. It issues no further `fifo_req` until space frees.
- Reset mid-record:
  - Partial digit and partial record are discarded; pending output is dropped.
  - The first record after reset starts with the next bit popped.
  - FIFO flushing is the caller's job, via `fifo_rst`.

## Test plan
- Reset: hold `rst_n`=0 with FIFO non-empty → `fifo_req`=0, `out_valid`=0, `rec_count`=0. After release, first `fifo_req` follows within 1 cycle.
- Single record, `out_ready`=1: feed the 100 bits of `5um2o2dhfj2q5lvdchhq` MSB-first → exactly 21 bytes `"5um2o2dhfj2q5lvdchhq\n"`.
  - `rec_count`=1.
  - No two consecutive `fifo_req`.
- Backpressure: same record with `out_ready` toggling 1/0 and then held low for 40 cycles → identical byte sequence with no drops or duplicates.
  - During the stall, pop count ≤ 5 beyond the last accepted digit.
- Empty gaps: `fifo_empty` asserted for random 0–10 cycle gaps between bits → same output. `fifo_req` is never issued while `fifo_empty`=1.
- Overflow: pulse `fifo_oflow` for 1 cycle at bit 37 of record 1 → record 1 ends with `"!\n"`, record 2 ends with plain `"\n"`.
  - `rec_count`=2.
- Mid-record reset: assert `rst_n`=0 after 53 bits, then feed a fresh record → only that record's 21 bytes appear.
  - `rec_count`=1.
  - Digit mapping checked for values 0, 9, 10 and 31: `'0'`, `'9'`, `'a'`, `'v'`.
